// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: rx_state_t receiver state encoding, default frame constants,
//           calcParity() returns the parity bit a transmitter would append.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Narrower data words are zero-extended by the caller; zeros do not
  // change the XOR, so one 8-bit helper serves every DATA_BITS setting.
  function automatic logic calcParity(input logic [7:0] data, input logic oddParity);
    return (^data) ^ oddParity;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 1 (line idle).
// Latency: 2 Clock cycles from AsyncIn to SyncOut.
// Backpressure: none; samples every Clock.
// Ports: Clock, Reset (async, active-high), AsyncIn (raw pin), SyncOut (synchronized level).
module uart_sync2 (
  input  logic Clock,
  input  logic Reset,
  input  logic AsyncIn,
  output logic SyncOut
);

  logic stage1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stage1  <= 1'b1;
      SyncOut <= 1'b1;
    end else begin
      stage1  <= AsyncIn;
      SyncOut <= stage1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: oversampled start/data/stop recovery, byte strobe and frame-error strobe.
// Latency: ~(0.5 + DATA_BITS) * OVERSAMPLE + STOP_BIT_TICKS Ticks after the start edge, plus 3 Clocks.
// Backpressure: none; the consumer must take DataOut on the RxDone pulse.
// Ports: Clock, Reset (async, active-high), Tick (oversample strobe), Rx (serial pin),
//        DataOut (last good byte, held), RxDone / FrameError (one-cycle pulses), Busy (not IDLE).
// Optional: define UART_RX_PARITY_EN to add a parity bit, parameter PARITY_ODD and output ParityError.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS      = UART_DATA_BITS,
  parameter int OVERSAMPLE     = UART_OVERSAMPLE,
  parameter int STOP_BIT_TICKS = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD     = 1'b0
`endif
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 RxDone,
  output logic                 FrameError,
`ifdef UART_RX_PARITY_EN
  output logic                 ParityError,
`endif
  output logic                 Busy
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_BIT_TICKS) ? OVERSAMPLE : STOP_BIT_TICKS;
  localparam int TW       = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_END  = TW'(STOP_BIT_TICKS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t              state, stateNext;
  logic [TW-1:0]          tickCount, tickNext;
  logic [BW-1:0]          bitCount, bitNext;
  logic [DATA_BITS-1:0]   shiftReg, shiftNext;
  logic [DATA_BITS-1:0]   dataNext;
  logic                   doneNext, ferrNext;
  logic                   breakLock, lockNext;
  logic                   rxSync;
`ifdef UART_RX_PARITY_EN
  logic                   parityReg, parityNext;
  logic                   perrNext;
`endif

  uart_sync2 uSync (
    .Clock   (Clock),
    .Reset   (Reset),
    .AsyncIn (Rx),
    .SyncOut (rxSync)
  );

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      tickCount  <= '0;
      bitCount   <= '0;
      shiftReg   <= '0;
      DataOut    <= '0;
      RxDone     <= 1'b0;
      FrameError <= 1'b0;
      breakLock  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityReg   <= 1'b0;
      ParityError <= 1'b0;
`endif
    end else begin
      state      <= stateNext;
      tickCount  <= tickNext;
      bitCount   <= bitNext;
      shiftReg   <= shiftNext;
      DataOut    <= dataNext;
      RxDone     <= doneNext;
      FrameError <= ferrNext;
      breakLock  <= lockNext;
`ifdef UART_RX_PARITY_EN
      parityReg   <= parityNext;
      ParityError <= perrNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    tickNext  = tickCount;
    bitNext   = bitCount;
    shiftNext = shiftReg;
    dataNext  = DataOut;
    doneNext  = 1'b0;
    ferrNext  = 1'b0;
    lockNext  = breakLock;
`ifdef UART_RX_PARITY_EN
    parityNext = parityReg;
    perrNext   = 1'b0;
`endif

    // A held-low line (break) must return high before a new start bit is accepted.
    if (rxSync) lockNext = 1'b0;

    case (state)
      IDLE: begin
        if (Tick && !rxSync && !breakLock) begin
          stateNext = START;
          tickNext  = '0;
        end
      end

      START: begin
        if (Tick) begin
          if (tickCount == MID_START) begin
            tickNext = '0;
            if (rxSync) begin
              stateNext = IDLE;          // glitch shorter than half a bit
            end else begin
              stateNext = DATA;
              bitNext   = '0;
            end
          end else begin
            tickNext = tickCount + TW'(1);
          end
        end
      end

      DATA: begin
        if (Tick) begin
          if (tickCount == BIT_END) begin
            tickNext  = '0;
            // LSB arrives first, so bits enter at the top and drift down.
            shiftNext = shiftReg >> 1;
            shiftNext[DATA_BITS-1] = rxSync;
            if (bitCount == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              stateNext = PARITY;
`else
              stateNext = STOP;
`endif
            end else begin
              bitNext = bitCount + BW'(1);
            end
          end else begin
            tickNext = tickCount + TW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (Tick) begin
          if (tickCount == BIT_END) begin
            tickNext   = '0;
            parityNext = rxSync;
            stateNext  = STOP;
          end else begin
            tickNext = tickCount + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (Tick) begin
          if (tickCount == STOP_END) begin
            tickNext  = '0;
            stateNext = IDLE;
            if (!rxSync) begin
              ferrNext = 1'b1;
              lockNext = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parityReg != calcParity(8'(shiftReg), PARITY_ODD)) begin
              perrNext = 1'b1;
`endif
            end else begin
              dataNext = shiftReg;
              doneNext = 1'b1;
            end
          end else begin
            tickNext = tickCount + TW'(1);
          end
        end
      end

      default: begin
        stateNext = IDLE;
        tickNext  = '0;
        bitNext   = '0;
      end
    endcase
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive stage, the downstream consumer of the transmit serial line. Samples the line using the 16x baud Tick pulse, recovers 8N1 frames (LSB first) and presents each byte with a one-cycle RxDone strobe. Also flags frame errors. Sits between the external RX pin and the byte-wide consumer logic.

Parameters:
DATA_BITS, 8, data bits per frame (1..8)
OVERSAMPLE, 16, Tick pulses per bit period; must be even and at least 4
STOP_BIT_TICKS, 16, Tick pulses counted in the stop bit before it is sampled

Ports:
Clock  input  1  system clock (50MHz)
Reset  input  1  asynchronous reset, active-high
Tick  input  1  one-cycle pulse from the baud generator at OVERSAMPLE x baud
Rx  input  1  asynchronous serial line; idles high
DataOut  output  DATA_BITS  last received byte; held until the next good frame
RxDone  output  1  one-cycle pulse when DataOut updates
FrameError  output  1  one-cycle pulse when the stop bit is sampled low
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-high; one clock.
- Reset values: DataOut=0, RxDone=0, FrameError=0, Busy=0. State=IDLE, counters=0, both synchronizer flops=1.
- Rx passes through a 2-flop synchronizer (RxSync). All decisions use RxSync. Latency from pin to RxSync is 2 Clock cycles.
- Tick counter (TickCount, width clog2(max(OVERSAMPLE,STOP_BIT_TICKS))) and bit counter advance only on cycles with Tick=1. No-Tick cycles hold all state.
- IDLE: on Tick with RxSync=0 and BreakLock=0, go to START with TickCount=0. While BreakLock=1, stay in IDLE; BreakLock clears the first cycle RxSync=1.
- START: on Tick, increment TickCount. When TickCount==OVERSAMPLE/2-1 (mid start bit):
  - RxSync=1: false start, return to IDLE, no outputs.
  - Otherwise: go to DATA with TickCount=0, BitCount=0.
- DATA: on Tick, when TickCount==OVERSAMPLE-1:
  - Shift RxSync into the MSB of the shift register (right shift, LSB-first); TickCount=0.
  - If BitCount==DATA_BITS-1, go to STOP; else BitCount+1.
  - Otherwise TickCount+1.
- STOP: on Tick, when TickCount==STOP_BIT_TICKS-1, sample RxSync and go to IDLE:
  - RxSync=1: DataOut<=shift register, RxDone=1 for exactly one Clock.
  - RxSync=0: FrameError=1 for one Clock, DataOut unchanged, BreakLock<=1.
- RxDone and FrameError are registered and asserted the cycle after the sampling Tick. They are never both high.
- Total frame latency: start edge to RxDone is about (0.5 + DATA_BITS) x OVERSAMPLE + STOP_BIT_TICKS Ticks, plus 3 Clocks.
- Tick held high continuously is legal: it degrades to one step per Clock.
- Reset mid-frame aborts immediately. No RxDone or FrameError is emitted for the partial frame.
- Unused state encodings recover to IDLE on the next Clock.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds output ParityError (1 bit, reset 0).
  - Adds state PARITY between DATA and STOP, lasting OVERSAMPLE Ticks, sampled at the end like a data bit.
  - At the STOP sample with a good stop bit and a parity mismatch: ParityError pulses for one Clock instead of RxDone, and DataOut is unchanged.
  - A frame error takes precedence over a parity error.
- Undefined: no PARITY state, no ParityError port; behaviour exactly as above.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - default constants UART_DATA_BITS=8 and UART_OVERSAMPLE=16;
  - a parity helper function.
- One sub-module, uart_sync2: a 2-flop synchronizer with reset value 1, reusable for other async inputs.

Test Plan:
- Byte 0x55 at OVERSAMPLE=16, Tick every 25 Clocks, clean stop -> one RxDone pulse, DataOut=0x55, FrameError=0, Busy falls with RxDone.
- Back-to-back frames 0xA5 then 0xFF with no idle gap -> two RxDone pulses, DataOut=0xA5 then 0xFF.
- Rx low glitch of 4 Ticks then high -> returns to IDLE, no RxDone, no FrameError, DataOut unchanged.
- Frame 0x3C with stop bit driven 0 -> FrameError pulse, no RxDone, DataOut keeps previous value. Line held low 3 more frame times -> no further pulses until Rx returns high.
- Reset asserted during bit 4 of a frame -> all outputs 0 in the same cycle. After release, a clean 0x81 frame -> RxDone, DataOut=0x81.
- With UART_RX_PARITY_EN and even parity: 0x07 with parity bit 1 -> RxDone. Parity bit 0 -> ParityError only.
